instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 CLK  input  1  single clock; all state changes on rising edge.
REQ-002 MRSTn  input  1  reset, asynchronous assert, active-low.
REQ-003 req_valid  input  1  encode request present.
REQ-004 req_ready  output  1  encoder accepts request this cycle.
REQ-005 req_op  input  5  operation code, enumerated in package (0 NOP, 1-10 ADD..NOR, 11-13 SLL/SRL/SRA, 14-21 ADDI..LUI, 22 LW, 23 SW, 24-27 BEQ/BNE/BLEZ/BGTZ, 28 J, 29 JAL, 30 JR, 31 LI pseudo-op).
REQ-006 req_rs, req_rt, req_rd, req_sa  input  5 each  register/shift fields.
REQ-007 req_imm  input  32  immediate, byte branch offset, byte jump address, or LI constant.
REQ-008 ir  output  32  encoded MIPS-Lite instruction word.
REQ-009 ir_valid  output  1  ir holds a word; ir_ready  input  1  consumer takes word.
REQ-010 ir_last  output  1  current ir is final word of its request.
REQ-011 err  output  1  one-cycle pulse: request rejected.
REQ-012 word_count  output  16  count of words transferred on ir.

Function
REQ-013 Request accepted when req_valid && req_ready; req_ready = (state==IDLE) && (!ir_valid || ir_ready).
REQ-014 Word transferred when ir_valid && ir_ready; while ir_valid && !ir_ready, ir/ir_last held stable.
REQ-015 Latency: first word on ir the cycle after acceptance; no bubble when consumer ready.
REQ-016 FSM states IDLE, EMIT2: IDLE->EMIT2 on accepting LI needing two words; EMIT2 loads second word on first-word transfer, then ->IDLE on its transfer.
REQ-017 R-type: op 000000, fields rs/rt/rd/sa/funct per standard MIPS; NOP = 32'h0; JR = {SPECIAL, rs, 15'b0, 001000}.
REQ-018 I-type ALU/LUI/LW/SW: {opcode, rs, rt, req_imm[15:0]}; LUI ignores rs (encodes 0).
REQ-019 Branches: req_imm[1:0]!=0 or req_imm[31:17] not all equal to req_imm[17] -> reject; else imm field = req_imm[17:2]; BLEZ/BGTZ rt field = 0.
REQ-020 J/JAL: req_imm[1:0]!=0 -> reject; target field = req_imm[27:2].
REQ-021 LI: constant in signed 16-bit range -> one word ADDIU rt,r0,imm[15:0]; else imm[15:0]==0 -> one word LUI rt,imm[31:16]; else LUI rt,imm[31:16] then ORI rt,rt,imm[15:0].
REQ-022 Reject: request consumed, no word emitted, err high exactly the cycle after acceptance, ir_valid unaffected.
REQ-023 ir_last=1 on every single-word output and on second LI word only.
REQ-024 word_count increments per transfer, wraps 16'hFFFF->0.

Reset
REQ-025 MRSTn low: state IDLE, ir_valid 0, ir 0, ir_last 0, err 0, word_count 0 immediately; pending second LI word discarded.
REQ-026 req_ready may assert on first rising edge after MRSTn deasserts.

Structure
REQ-027 Package holds req_op enum, MIPS opcode/funct constants (SPECIAL, ADDIU, LUI, ORI, BEQ, ...), FSM state type.
REQ-028 One combinational sub-module instr_field_pack: (op, fields, imm) -> word0, word1, two_words, reject; instr_encoder holds FSM, output register, counter.

Verification
REQ-029 ADD rd=3 rs=1 rt=2, ir_ready=1 -> next cycle ir=32'h00221820, ir_last=1, word_count=1.
REQ-030 LI rt=8 imm=32'h12345678 -> ir=32'h3C081234 (ir_last 0) then 32'h35085678 (ir_last 1); req_ready low between.
REQ-031 LI rt=8 imm=32'hFFFFFFFC -> single ir=32'h2408FFFC, ir_last=1.
REQ-032 BEQ rs=1 rt=2 imm=-8 -> ir=32'h1022FFFE; BEQ imm=6 -> err pulse, no ir_valid.
REQ-033 ir_ready=0 three cycles after ORI request -> ir stable, req_ready=0; release -> one transfer only.
REQ-034 MRSTn pulsed low after first LI word transfers -> ir_valid=0, second word never appears, word_count=0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_pkg
// Purpose  : Request opcodes, MIPS-Lite opcode/funct constants, FSM state type
//            and word-packing helpers shared by the instruction encoder.
// Revision : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_ADD   = 5'd1,
        OP_ADDU  = 5'd2,
        OP_SUB   = 5'd3,
        OP_SUBU  = 5'd4,
        OP_SLT   = 5'd5,
        OP_SLTU  = 5'd6,
        OP_AND   = 5'd7,
        OP_OR    = 5'd8,
        OP_XOR   = 5'd9,
        OP_NOR   = 5'd10,
        OP_SLL   = 5'd11,
        OP_SRL   = 5'd12,
        OP_SRA   = 5'd13,
        OP_ADDI  = 5'd14,
        OP_ADDIU = 5'd15,
        OP_SLTI  = 5'd16,
        OP_SLTIU = 5'd17,
        OP_ANDI  = 5'd18,
        OP_ORI   = 5'd19,
        OP_XORI  = 5'd20,
        OP_LUI   = 5'd21,
        OP_LW    = 5'd22,
        OP_SW    = 5'd23,
        OP_BEQ   = 5'd24,
        OP_BNE   = 5'd25,
        OP_BLEZ  = 5'd26,
        OP_BGTZ  = 5'd27,
        OP_J     = 5'd28,
        OP_JAL   = 5'd29,
        OP_JR    = 5'd30,
        OP_LI    = 5'd31
    } req_op_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_BLEZ    = 6'h06;
    localparam logic [5:0] OPC_BGTZ    = 6'h07;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_EMIT2 = 1'b1
    } state_e;

    function automatic logic [5:0] funct_of(input req_op_e op);
        case (op)
            OP_ADD:  funct_of = FN_ADD;
            OP_ADDU: funct_of = FN_ADDU;
            OP_SUB:  funct_of = FN_SUB;
            OP_SUBU: funct_of = FN_SUBU;
            OP_SLT:  funct_of = FN_SLT;
            OP_SLTU: funct_of = FN_SLTU;
            OP_AND:  funct_of = FN_AND;
            OP_OR:   funct_of = FN_OR;
            OP_XOR:  funct_of = FN_XOR;
            OP_NOR:  funct_of = FN_NOR;
            OP_SLL:  funct_of = FN_SLL;
            OP_SRL:  funct_of = FN_SRL;
            OP_SRA:  funct_of = FN_SRA;
            OP_JR:   funct_of = FN_JR;
            default: funct_of = 6'h00;
        endcase
    endfunction

    function automatic logic [5:0] opcode_of(input req_op_e op);
        case (op)
            OP_ADDI:  opcode_of = OPC_ADDI;
            OP_ADDIU: opcode_of = OPC_ADDIU;
            OP_SLTI:  opcode_of = OPC_SLTI;
            OP_SLTIU: opcode_of = OPC_SLTIU;
            OP_ANDI:  opcode_of = OPC_ANDI;
            OP_ORI:   opcode_of = OPC_ORI;
            OP_XORI:  opcode_of = OPC_XORI;
            OP_LUI:   opcode_of = OPC_LUI;
            OP_LW:    opcode_of = OPC_LW;
            OP_SW:    opcode_of = OPC_SW;
            OP_BEQ:   opcode_of = OPC_BEQ;
            OP_BNE:   opcode_of = OPC_BNE;
            OP_BLEZ:  opcode_of = OPC_BLEZ;
            OP_BGTZ:  opcode_of = OPC_BGTZ;
            OP_J:     opcode_of = OPC_J;
            OP_JAL:   opcode_of = OPC_JAL;
            default:  opcode_of = OPC_SPECIAL;
        endcase
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa,
                                           input logic [5:0] fn);
        r_type = {OPC_SPECIAL, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        i_type = {opc, rs, rt, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_if
// Purpose  : Request and instruction-word stream bundle of the encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_encoder_if;

    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [4:0]  req_sa;
    logic [31:0] req_imm;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        ir_last;
    logic        err;
    logic [15:0] word_count;

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_sa, req_imm, ir_ready,
        input  req_ready, ir, ir_valid, ir_last, err, word_count
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_sa, req_imm, ir_ready,
        output req_ready, ir, ir_valid, ir_last, err, word_count
    );

endinterface
`default_nettype wire

// File: rtl/instr_encoder_field_pack.sv
`default_nettype none
// ============================================================================
// Module   : instr_field_pack
// Purpose  : Combinational packer from an encode request to one or two
//            MIPS-Lite words, flagging malformed branch/jump offsets.
// Revision : 1.0 - initial release
// ============================================================================
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  req_op_e     op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  sa_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word0_o,
    output logic [31:0] word1_o,
    output logic        two_words_o,
    output logic        reject_o
);

    logic w_br_ok;
    logic w_li_short;

    // Branch offsets must be word aligned and fit the 18-bit signed byte range
    assign w_br_ok    = (imm_i[1:0] == 2'b00) && (imm_i[31:17] == {15{imm_i[17]}});
    assign w_li_short = (imm_i[31:15] == {17{imm_i[15]}});

    always_comb begin
        word0_o     = '0;
        word1_o     = '0;
        two_words_o = 1'b0;
        reject_o    = 1'b0;
        if (op_i inside {[OP_ADD:OP_NOR]}) begin
            word0_o = r_type(rs_i, rt_i, rd_i, 5'd0, funct_of(op_i));
        end else if (op_i inside {[OP_SLL:OP_SRA]}) begin
            word0_o = r_type(5'd0, rt_i, rd_i, sa_i, funct_of(op_i));
        end else if (op_i == OP_JR) begin
            word0_o = r_type(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
        end else if (op_i inside {[OP_ADDI:OP_SW]}) begin
            word0_o = i_type(opcode_of(op_i), (op_i == OP_LUI) ? 5'd0 : rs_i, rt_i, imm_i[15:0]);
        end else if (op_i inside {[OP_BEQ:OP_BGTZ]}) begin
            if (!w_br_ok) begin
                reject_o = 1'b1;
            end else begin
                word0_o = i_type(opcode_of(op_i), rs_i,
                                 (op_i inside {OP_BLEZ, OP_BGTZ}) ? 5'd0 : rt_i,
                                 imm_i[17:2]);
            end
        end else if (op_i inside {OP_J, OP_JAL}) begin
            if (imm_i[1:0] != 2'b00) begin
                reject_o = 1'b1;
            end else begin
                word0_o = {opcode_of(op_i), imm_i[27:2]};
            end
        end else if (op_i == OP_LI) begin
            if (w_li_short) begin
                word0_o = i_type(OPC_ADDIU, 5'd0, rt_i, imm_i[15:0]);
            end else begin
                word0_o = i_type(OPC_LUI, 5'd0, rt_i, imm_i[31:16]);
                if (imm_i[15:0] != 16'h0000) begin
                    two_words_o = 1'b1;
                    word1_o     = i_type(OPC_ORI, rt_i, rt_i, imm_i[15:0]);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Handshaked MIPS-Lite instruction encoder with registered output
//            word, two-word LI expansion and transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic              CLK,
    input  logic              MRSTn,
    instr_encoder_if.slave    bus
);

    logic [31:0] w_word0;
    logic [31:0] w_word1;
    logic        w_two;
    logic        w_reject;
    logic        w_ready;
    logic        w_accept;
    logic        w_xfer;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] word1_q, word1_d;
    logic        ir_valid_q, ir_valid_d;
    logic        ir_last_q, ir_last_d;
    logic        err_q, err_d;
    logic [15:0] word_count_q, word_count_d;

    instr_field_pack u_pack (
        .op_i        (req_op_e'(bus.req_op)),
        .rs_i        (bus.req_rs),
        .rt_i        (bus.req_rt),
        .rd_i        (bus.req_rd),
        .sa_i        (bus.req_sa),
        .imm_i       (bus.req_imm),
        .word0_o     (w_word0),
        .word1_o     (w_word1),
        .two_words_o (w_two),
        .reject_o    (w_reject)
    );

    assign w_ready  = (state_q == ST_IDLE) && (!ir_valid_q || bus.ir_ready);
    assign w_accept = bus.req_valid && w_ready;
    assign w_xfer   = ir_valid_q && bus.ir_ready;

    always_ff @(posedge CLK or negedge MRSTn) begin
        if (!MRSTn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept && !w_reject && w_two) state_d = ST_EMIT2;
            ST_EMIT2: if (w_xfer && ir_last_q)            state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ir_d         = ir_q;
        ir_valid_d   = ir_valid_q && !w_xfer;
        ir_last_d    = ir_last_q;
        word1_d      = word1_q;
        err_d        = 1'b0;
        word_count_d = word_count_q + {15'd0, w_xfer};
        if (w_accept) begin
            if (w_reject) begin
                err_d = 1'b1;
            end else begin
                ir_d       = w_word0;
                ir_valid_d = 1'b1;
                ir_last_d  = !w_two;
                word1_d    = w_word1;
            end
        end else if ((state_q == ST_EMIT2) && w_xfer && !ir_last_q) begin
            // First LI word leaves: present the stashed ORI without a bubble
            ir_d       = word1_q;
            ir_valid_d = 1'b1;
            ir_last_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge MRSTn) begin
        if (!MRSTn) begin
            ir_q         <= '0;
            word1_q      <= '0;
            ir_valid_q   <= 1'b0;
            ir_last_q    <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
        end else begin
            ir_q         <= ir_d;
            word1_q      <= word1_d;
            ir_valid_q   <= ir_valid_d;
            ir_last_q    <= ir_last_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.ir         = ir_q;
    assign bus.ir_valid   = ir_valid_q;
    assign bus.ir_last    = ir_last_q;
    assign bus.err        = err_q;
    assign bus.word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Directed plus randomized bench for instr_encoder with a
//            queue-based reference model of the emitted word stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder u_dut (
        .CLK   (clk),
        .MRSTn (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] w;
        logic        last;
        logic        two;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    logic        exp_err = 1'b0;
    logic [15:0] exp_cnt = 16'd0;
    logic [31:0] r;
    logic [31:0] ri;
    logic [31:0] hold_ir;

    // funct per op 0..13, major opcode per op 14..29
    logic [5:0] funct_t [0:13] = '{6'h00, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B,
                                   6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03};
    logic [5:0] opc_t [14:29]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                   6'h23, 6'h2B, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        assert (act === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp_v);
        end
    endtask

    function automatic void model_encode(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [31:0] imm, output bit rej, output int n,
                                         output logic [31:0] w0, output logic [31:0] w1);
        longint v;
        logic [15:0] off;
        v   = longint'($signed(imm));
        rej = 1'b0;
        n   = 1;
        w0  = '0;
        w1  = '0;
        off = '0;
        if (op == 0) begin
            w0 = 32'h0;
        end else if (op <= 10) begin
            w0 = {6'd0, rs, rt, rd, 5'd0, funct_t[op]};
        end else if (op <= 13) begin
            w0 = {6'd0, 5'd0, rt, rd, sa, funct_t[op]};
        end else if (op <= 23) begin
            w0 = {opc_t[op], (op == 21) ? 5'd0 : rs, rt, imm[15:0]};
        end else if (op <= 27) begin
            if ((v % 4) != 0 || v < -131072 || v > 131071) begin
                rej = 1'b1;
                n   = 0;
            end else begin
                off = 16'(v / 4);
                w0  = {opc_t[op], rs, (op >= 26) ? 5'd0 : rt, off};
            end
        end else if (op <= 29) begin
            if ((imm % 4) != 0) begin
                rej = 1'b1;
                n   = 0;
            end else begin
                w0 = {opc_t[op], 26'(imm / 4)};
            end
        end else if (op == 30) begin
            w0 = {6'd0, rs, 15'd0, 6'h08};
        end else begin
            if (v >= -32768 && v <= 32767) begin
                w0 = {6'h09, 5'd0, rt, imm[15:0]};
            end else if ((imm % 65536) == 0) begin
                w0 = {6'h0F, 5'd0, rt, 16'(imm / 65536)};
            end else begin
                n  = 2;
                w0 = {6'h0F, 5'd0, rt, 16'(imm / 65536)};
                w1 = {6'h0D, rt, rt, 16'(imm % 65536)};
            end
        end
    endfunction

    // One clock: compare against the model, then advance the model by the edge
    task automatic tick(input bit chk);
        bit          ev, er, acc, xf, rej;
        int          n, op_s;
        logic [4:0]  rs_s, rt_s, rd_s, sa_s;
        logic [31:0] imm_s, w0, w1;
        #1;
        ev = (q.size() != 0);
        er = (q.size() == 0 || !q[0].two) && (!ev || bus.ir_ready);
        if (chk) begin
            check("ir_valid", bus.ir_valid, ev);
            check("req_ready", bus.req_ready, er);
            check("err", bus.err, exp_err);
            check("word_count", bus.word_count, exp_cnt);
            if (ev) begin
                check("ir", bus.ir, q[0].w);
                check("ir_last", bus.ir_last, q[0].last);
            end
        end
        acc   = bus.req_valid && er;
        xf    = ev && bus.ir_ready;
        op_s  = int'(bus.req_op);
        rs_s  = bus.req_rs;
        rt_s  = bus.req_rt;
        rd_s  = bus.req_rd;
        sa_s  = bus.req_sa;
        imm_s = bus.req_imm;
        @(posedge clk);
        if (xf) begin
            void'(q.pop_front());
            exp_cnt++;
        end
        exp_err = 1'b0;
        if (acc) begin
            model_encode(op_s, rs_s, rt_s, rd_s, sa_s, imm_s, rej, n, w0, w1);
            if (rej) begin
                exp_err = 1'b1;
            end else if (n == 1) begin
                q.push_back('{w: w0, last: 1'b1, two: 1'b0});
            end else begin
                q.push_back('{w: w0, last: 1'b0, two: 1'b1});
                q.push_back('{w: w1, last: 1'b1, two: 1'b1});
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sa, input logic [31:0] imm);
        bus.req_valid = v;
        bus.req_op    = 5'(op);
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        bus.req_rd    = rd;
        bus.req_sa    = sa;
        bus.req_imm   = imm;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_ir_valid", bus.ir_valid, 1'b0);
        check("rst_ir", bus.ir, 32'h0);
        check("rst_ir_last", bus.ir_last, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_word_count", bus.word_count, 16'h0);
        q.delete();
        exp_cnt = 16'd0;
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ir_ready = 1'b0;
        drive(1'b0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        #3;
        check("por_ir_valid", bus.ir_valid, 1'b0);
        check("por_ir", bus.ir, 32'h0);
        check("por_word_count", bus.word_count, 16'h0);
        check("por_err", bus.err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1);

        // ADD rd=3 rs=1 rt=2
        bus.ir_ready = 1'b1;
        drive(1'b1, 1, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
        tick(1'b1);
        bus.req_valid = 1'b0;
        check("add_ir", bus.ir, 32'h00221820);
        check("add_last", bus.ir_last, 1'b1);
        tick(1'b1);
        check("add_count", bus.word_count, 16'd1);

        // LI needing LUI+ORI
        drive(1'b1, 31, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
        tick(1'b1);
        bus.req_valid = 1'b0;
        check("li2_w0", bus.ir, 32'h3C081234);
        check("li2_last0", bus.ir_last, 1'b0);
        check("li2_ready0", bus.req_ready, 1'b0);
        tick(1'b1);
        check("li2_w1", bus.ir, 32'h35085678);
        check("li2_last1", bus.ir_last, 1'b1);
        check("li2_ready1", bus.req_ready, 1'b0);
        tick(1'b1);

        // LI in signed 16-bit range
        drive(1'b1, 31, 5'd0, 5'd8, 5'd0, 5'd0, 32'hFFFFFFFC);
        tick(1'b1);
        bus.req_valid = 1'b0;
        check("li1_w", bus.ir, 32'h2408FFFC);
        check("li1_last", bus.ir_last, 1'b1);
        tick(1'b1);

        // BEQ good and misaligned offsets
        drive(1'b1, 24, 5'd1, 5'd2, 5'd0, 5'd0, 32'hFFFFFFF8);
        tick(1'b1);
        bus.req_valid = 1'b0;
        check("beq_w", bus.ir, 32'h1022FFFE);
        tick(1'b1);
        drive(1'b1, 24, 5'd1, 5'd2, 5'd0, 5'd0, 32'h00000006);
        tick(1'b1);
        bus.req_valid = 1'b0;
        check("beq_rej_err", bus.err, 1'b1);
        check("beq_rej_valid", bus.ir_valid, 1'b0);
        tick(1'b1);
        check("beq_rej_err_clr", bus.err, 1'b0);

        // ORI under consumer backpressure
        bus.ir_ready = 1'b0;
        drive(1'b1, 19, 5'd4, 5'd5, 5'd0, 5'd0, 32'h0000ABCD);
        tick(1'b1);
        bus.req_valid = 1'b0;
        hold_ir = 32'h3485ABCD;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            check("stall_ir", bus.ir, hold_ir);
            check("stall_ready", bus.req_ready, 1'b0);
        end
        bus.ir_ready = 1'b1;
        tick(1'b1);
        tick(1'b1);
        check("stall_count", bus.word_count, 16'd6);
        check("stall_drained", bus.ir_valid, 1'b0);

        // Reset while the second LI word is pending
        drive(1'b1, 31, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
        tick(1'b1);
        bus.req_valid = 1'b0;
        tick(1'b1);
        check("pre_rst_w1", bus.ir, 32'h35085678);
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1);
        check("post_rst_valid", bus.ir_valid, 1'b0);
        check("post_rst_count", bus.word_count, 16'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom;
            case (r[3:2])
                2'd0: ri = $urandom;
                2'd1: begin ri = $urandom; ri = {{16{ri[15]}}, ri[15:0]}; end
                2'd2: begin
                    ri = $urandom;
                    ri = {{14{ri[17]}}, ri[17:0]};
                    if (r[4]) ri[1:0] = 2'b00;
                end
                default: begin ri = $urandom; ri = {ri[31:16], 16'h0000}; end
            endcase
            drive(r[0], int'($urandom_range(0, 31)), 5'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), ri);
            bus.ir_ready = (r[6:5] != 2'b00);
            tick(1'b1);
        end

        // Run the transfer counter up to its wrap point
        drive(1'b1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 70000 && exp_cnt != 16'hFFF0; i++) tick(1'b0);
        #1;
        check("wrap_reach", bus.word_count, 16'hFFF0);
        @(negedge clk);
        exp_cnt = exp_cnt + {15'd0, (q.size() != 0)};
        if (q.size() != 0) void'(q.pop_front());
        q.push_back('{w: 32'h0, last: 1'b1, two: 1'b0});
        for (int i = 0; i < 40; i++) tick(1'b1);
        bus.req_valid = 1'b0;
        tick(1'b1);
        tick(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
